prim_subreg_shadow_arb: RTL and testbench

- Parametrised shadowed control register.
- Each committed value needs two matching software writes.
- Hardware can update the register directly.
- Selectable software access mode: RW, W1C or W1S.
- Committed value is protected by an inverted shadow copy. Mismatches are flagged as update or storage errors.
- Instantiated per field inside register blocks. RESVAL is passed down as a packed struct/enum-derived constant.

---
 rtl/prim_subreg_shadow_arb.sv | 137 +++++++++++++
 tb/tb_prim_subreg_shadow_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_subreg_shadow_arb.sv
// Shadowed control register: two matching software writes commit a value, hardware may update directly.
// Optional phase timeout enabled by defining PRIM_SUBREG_SHADOW_TIMEOUT_EN.
module prim_subreg_shadow_arb #(
  parameter int unsigned    DW       = 8,
  parameter logic [DW-1:0]  RESVAL   = '0,
  parameter int unsigned    SWACCESS = 0,
  parameter int unsigned    TIMEOUT  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          re,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          de,
  input  logic [DW-1:0] d,
  output logic          qe,
  output logic [DW-1:0] q,
  output logic [DW-1:0] qs,
  output logic          phase,
  output logic          err_update,
  output logic          err_storage
);

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  phase_e        state_q, state_d;
  logic [DW-1:0] staged_q, staged_d;
  logic [DW-1:0] committed_q, committed_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic          qe_q, qe_d;
  logic          err_update_q, err_update_d;
  logic          err_storage_q;
  logic [DW-1:0] wr_val;

`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    if (SWACCESS == 1)      wr_val = committed_q & ~wd;
    else if (SWACCESS == 2) wr_val = committed_q | wd;
    else                    wr_val = wd;
  end

  always_comb begin
    state_d      = state_q;
    staged_d     = staged_q;
    committed_d  = committed_q;
    shadow_d     = shadow_q;
    qe_d         = 1'b0;
    err_update_d = 1'b0;
    if (we) begin
      if (state_q == PH_FIRST) begin
        // Hardware update lands in committed; software's value wins in staged.
        staged_d = wr_val;
        state_d  = PH_SECOND;
        if (de) begin
          committed_d = d;
          shadow_d    = ~d;
        end
      end else if (wr_val == staged_q) begin
        committed_d = staged_q;
        shadow_d    = ~staged_q;
        state_d     = PH_FIRST;
        qe_d        = 1'b1;
      end else begin
        state_d      = PH_FIRST;
        err_update_d = 1'b1;
        if (de) begin
          committed_d = d;
          shadow_d    = ~d;
        end
      end
    end else begin
      if (re) state_d = PH_FIRST;
      if (de) begin
        committed_d = d;
        shadow_d    = ~d;
        staged_d    = d;
      end
    end
`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
    cnt_d = '0;
    if (!we && !re && state_q == PH_SECOND) begin
      // Counter holds completed idle cycles; the TIMEOUT-th idle cycle expires the phase.
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d      = PH_FIRST;
        err_update_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= PH_FIRST;
      staged_q      <= RESVAL;
      committed_q   <= RESVAL;
      shadow_q      <= ~RESVAL;
      qe_q          <= 1'b0;
      err_update_q  <= 1'b0;
      err_storage_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      staged_q      <= staged_d;
      committed_q   <= committed_d;
      shadow_q      <= shadow_d;
      qe_q          <= qe_d;
      err_update_q  <= err_update_d;
      err_storage_q <= err_storage_q | (committed_q != ~shadow_q);
    end
  end

`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign q           = committed_q;
  assign qs          = committed_q;
  assign phase       = (state_q == PH_SECOND);
  assign qe          = qe_q;
  assign err_update  = err_update_q;
  assign err_storage = err_storage_q;

endmodule

// File: tb/tb_prim_subreg_shadow_arb.sv
// Bench for prim_subreg_shadow_arb: RW/W1C/W1S instances driven in parallel against a per-instance model.
module tb_prim_subreg_shadow_arb;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_s;
  logic re_s, we_s, de_s;
  logic [7:0] wd_s, d_s;

  logic       qe_w   [3];
  logic [7:0] q_w    [3];
  logic [7:0] qs_w   [3];
  logic       ph_w   [3];
  logic       eu_w   [3];
  logic       es_w   [3];

  always #5 clk = ~clk;

  prim_subreg_shadow_arb #(.DW(8), .RESVAL(8'h5A), .SWACCESS(0), .TIMEOUT(TO)) dut_rw (
    .clk_i(clk), .rst_i(rst_s), .re(re_s), .we(we_s), .wd(wd_s), .de(de_s), .d(d_s),
    .qe(qe_w[0]), .q(q_w[0]), .qs(qs_w[0]), .phase(ph_w[0]),
    .err_update(eu_w[0]), .err_storage(es_w[0]));

  prim_subreg_shadow_arb #(.DW(8), .RESVAL(8'hFF), .SWACCESS(1), .TIMEOUT(TO)) dut_w1c (
    .clk_i(clk), .rst_i(rst_s), .re(re_s), .we(we_s), .wd(wd_s), .de(de_s), .d(d_s),
    .qe(qe_w[1]), .q(q_w[1]), .qs(qs_w[1]), .phase(ph_w[1]),
    .err_update(eu_w[1]), .err_storage(es_w[1]));

  prim_subreg_shadow_arb #(.DW(8), .RESVAL(8'h00), .SWACCESS(2), .TIMEOUT(TO)) dut_w1s (
    .clk_i(clk), .rst_i(rst_s), .re(re_s), .we(we_s), .wd(wd_s), .de(de_s), .d(d_s),
    .qe(qe_w[2]), .q(q_w[2]), .qs(qs_w[2]), .phase(ph_w[2]),
    .err_update(eu_w[2]), .err_storage(es_w[2]));

  // Reference model: one entry per instance (0=RW, 1=W1C, 2=W1S)
  logic [7:0] m_rv     [3];
  logic [7:0] m_commit [3];
  logic [7:0] m_staged [3];
  bit         m_phase  [3];
  bit         m_qe     [3];
  bit         m_eu     [3];
  bit         m_es     [3];
  int         m_idle   [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] fw(input int mode, input logic [7:0] x, input logic [7:0] w);
    if (mode == 1) return x & ~w;
    if (mode == 2) return x | w;
    return w;
  endfunction

  task automatic model_reset();
    m_rv[0] = 8'h5A; m_rv[1] = 8'hFF; m_rv[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      m_commit[i] = m_rv[i];
      m_staged[i] = m_rv[i];
      m_phase[i]  = 0;
      m_qe[i]     = 0;
      m_eu[i]     = 0;
      m_es[i]     = 0;
      m_idle[i]   = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] f;
      f = fw(i, m_commit[i], wd_s);
      m_qe[i] = 0;
      m_eu[i] = 0;
      if (we_s) begin
        m_idle[i] = 0;
        if (!m_phase[i]) begin
          m_staged[i] = f;
          m_phase[i]  = 1;
          if (de_s) m_commit[i] = d_s;
        end else begin
          m_phase[i] = 0;
          if (f == m_staged[i]) begin
            m_commit[i] = m_staged[i];
            m_qe[i]     = 1;
          end else begin
            m_eu[i] = 1;
            if (de_s) m_commit[i] = d_s;
          end
        end
      end else begin
        if (de_s) begin
          m_commit[i] = d_s;
          m_staged[i] = d_s;
        end
        if (re_s) begin
          m_phase[i] = 0;
          m_idle[i]  = 0;
        end
`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
        else if (m_phase[i]) begin
          m_idle[i]++;
          if (m_idle[i] == TO) begin
            m_phase[i] = 0;
            m_eu[i]    = 1;
            m_idle[i]  = 0;
          end
        end
`endif
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("q%0d", i),  q_w[i],  m_commit[i]);
      check($sformatf("qs%0d", i), qs_w[i], m_commit[i]);
      check($sformatf("phase%0d", i), ph_w[i], m_phase[i]);
      check($sformatf("qe%0d", i), qe_w[i], m_qe[i]);
      check($sformatf("err_update%0d", i), eu_w[i], m_eu[i]);
      check($sformatf("err_storage%0d", i), es_w[i], m_es[i]);
    end
  endtask

  task automatic cycle(input bit r, input bit w, input logic [7:0] wdv, input bit dev, input logic [7:0] dv);
    re_s = r; we_s = w; wd_s = wdv; de_s = dev; d_s = dv;
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic do_reset();
    #2 rst_s = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst_s = 1'b0;
  endtask

  initial begin
    logic [7:0] last_wd;
    logic [7:0] sh_bad;
    rst_s = 1'b1; re_s = 0; we_s = 0; de_s = 0; wd_s = '0; d_s = '0;
    model_reset();
    #3;
    check_all();
    check("reset_q", q_w[0], 8'h5A);
    @(negedge clk);
    rst_s = 1'b0;

    // RW double write
    cycle(0, 1, 8'h3C, 0, 8'h00);
    check("rw_first_q", q_w[0], 8'h5A);
    check("rw_first_phase", ph_w[0], 1'b1);
    cycle(0, 1, 8'h3C, 0, 8'h00);
    check("rw_commit_q", q_w[0], 8'h3C);
    check("rw_commit_qe", qe_w[0], 1'b1);
    idle(1);
    check("rw_qe_drop", qe_w[0], 1'b0);

    // RW mismatch
    cycle(0, 1, 8'h11, 0, 8'h00);
    cycle(0, 1, 8'h22, 0, 8'h00);
    check("mm_q", q_w[0], 8'h3C);
    check("mm_err", eu_w[0], 1'b1);
    check("mm_phase", ph_w[0], 1'b0);
    idle(1);
    check("mm_err_drop", eu_w[0], 1'b0);

    // re between writes restarts the sequence
    cycle(0, 1, 8'h77, 0, 8'h00);
    cycle(1, 0, 8'h00, 0, 8'h00);
    cycle(0, 1, 8'h77, 0, 8'h00);
    check("re_phase", ph_w[0], 1'b1);
    check("re_q", q_w[0], 8'h3C);
    cycle(1, 0, 8'h00, 0, 8'h00);

    // W1S from 00
    do_reset();
    cycle(0, 1, 8'h81, 0, 8'h00);
    cycle(0, 1, 8'h81, 0, 8'h00);
    check("w1s_q", q_w[2], 8'h81);

    // W1C from FF
    do_reset();
    cycle(0, 1, 8'h0F, 0, 8'h00);
    cycle(0, 1, 8'h0F, 0, 8'h00);
    check("w1c_q", q_w[1], 8'hF0);

    // de alongside committing write: software wins
    do_reset();
    cycle(0, 1, 8'h3C, 0, 8'h00);
    cycle(0, 1, 8'h3C, 1, 8'hA5);
    check("de_commit_q", q_w[0], 8'h3C);

    // de alone, then a matching pair
    cycle(0, 0, 8'h00, 1, 8'h96);
    check("de_only_q", q_w[0], 8'h96);
    cycle(0, 1, 8'h44, 1, 8'h12);
    cycle(0, 1, 8'h44, 0, 8'h00);

    // Reset mid-sequence
    cycle(0, 1, 8'h12, 0, 8'h00);
    check("mid_phase", ph_w[0], 1'b1);
    do_reset();
    check("mid_rst_phase", ph_w[0], 1'b0);
    check("mid_rst_q", q_w[0], 8'h5A);

    // Storage corruption on the RW instance
    sh_bad = ~m_commit[0] ^ 8'h01;
    force dut_rw.shadow_q = sh_bad;
    m_es[0] = 1;
    idle(1);
    check("storage_err", es_w[0], 1'b1);
    release dut_rw.shadow_q;
    cycle(0, 1, 8'h21, 0, 8'h00);
    cycle(0, 1, 8'h21, 0, 8'h00);
    idle(2);
    check("storage_sticky", es_w[0], 1'b1);
    do_reset();
    check("storage_clr", es_w[0], 1'b0);

`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
    cycle(0, 1, 8'h3C, 0, 8'h00);
    idle(TO);
    check("to_phase", ph_w[0], 1'b0);
    check("to_err", eu_w[0], 1'b1);
    idle(1);
    cycle(0, 1, 8'h3C, 0, 8'h00);
    idle(2);
    cycle(0, 1, 8'h3C, 0, 8'h00);
    check("to_late_commit", q_w[0], 8'h3C);
    check("to_late_qe", qe_w[0], 1'b1);
`endif

    // Randomized traffic; repeated write data makes matching pairs likely
    last_wd = 8'h00;
    for (int n = 0; n < 600; n++) begin
      bit r, w, de_r;
      logic [7:0] wv;
      r    = ($urandom % 8) == 0;
      w    = ($urandom % 2) == 0;
      de_r = ($urandom % 6) == 0;
      wv   = (($urandom % 3) == 0) ? 8'($urandom) : last_wd;
      last_wd = wv;
      cycle(r, w, wv, de_r, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
